// File: rtl/fpu_issue_ctrl_if.sv
// Handshake bundle between fpu_issue_ctrl, its upstream requester, the FPU and the response consumer.
// master is the controller's view; slave is the environment's view.
interface fpu_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_opcode;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;

  logic             fpu_valid_in;
  logic [1:0]       fpu_opcode;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic             fpu_valid_out;
  logic [31:0]      fpu_result;
  logic [3:0]       fpu_flags;
  logic             fpu_used_approx;
  logic             fpu_used_bf16;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_result;
  logic [3:0]       rsp_flags;
  logic [1:0]       rsp_mode;
  logic [1:0]       rsp_err;

  modport master (
    input  req_valid, req_opcode, req_a, req_b, req_tag,
    output req_ready,
    output fpu_valid_in, fpu_opcode, fpu_a, fpu_b,
    input  fpu_valid_out, fpu_result, fpu_flags, fpu_used_approx, fpu_used_bf16,
    output rsp_valid, rsp_tag, rsp_result, rsp_flags, rsp_mode, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_opcode, req_a, req_b, req_tag,
    input  req_ready,
    input  fpu_valid_in, fpu_opcode, fpu_a, fpu_b,
    output fpu_valid_out, fpu_result, fpu_flags, fpu_used_approx, fpu_used_bf16,
    input  rsp_valid, rsp_tag, rsp_result, rsp_flags, rsp_mode, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: queues tagged requests, issues them one at a time, returns tagged
// responses with mode/error information, counts mode usage and guards the FPU with a watchdog.
module fpu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  fpu_issue_ctrl_if.master bus,
  output logic [15:0]      cnt_fp32,
  output logic [15:0]      cnt_approx,
  output logic [15:0]      cnt_bf16,
  output logic             busy
);
  localparam int AW   = $clog2(DEPTH);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]     PTR_ONE  = 1;
  localparam logic [WD_W-1:0] WD_ONE   = 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef struct packed {
    logic [1:0]       opcode;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  req_t             fifo_mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic             fifo_empty, fifo_full, push, pop;
  req_t             req_in, head;

  state_t           state_reg, state_next;
  logic [WD_W-1:0]  wd_reg;
  logic             fpu_done, wd_expire;
  logic [1:0]       mode_in;

  logic [1:0]       fpu_op_reg;
  logic [31:0]      fpu_a_reg, fpu_b_reg;
  logic [TAG_W-1:0] rsp_tag_reg;
  logic [31:0]      rsp_result_reg;
  logic [3:0]       rsp_flags_reg;
  logic [1:0]       rsp_mode_reg, rsp_err_reg;
  logic [15:0]      cnt_sat [3];

  assign req_in     = {bus.req_opcode, bus.req_a, bus.req_b, bus.req_tag};
  assign head       = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push       = bus.req_valid && !fifo_full;
  assign pop        = (state_reg == S_IDLE) && !fifo_empty;
  assign mode_in    = bus.fpu_used_bf16 ? 2'b10 : (bus.fpu_used_approx ? 2'b01 : 2'b00);

  always_comb begin
    state_next = state_reg;
    fpu_done   = 1'b0;
    wd_expire  = 1'b0;
    case (state_reg)
      S_IDLE:  if (!fifo_empty) state_next = (head.opcode == 2'b11) ? S_RESP : S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (bus.fpu_valid_out) begin
          fpu_done   = 1'b1;
          state_next = S_RESP;
        end else if (wd_reg + WD_ONE == WD_LIMIT) begin
          wd_expire  = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP:  if (bus.rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Storage array has no reset so it maps onto RAM; only pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= req_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      wd_reg         <= '0;
      fpu_op_reg     <= '0;
      fpu_a_reg      <= '0;
      fpu_b_reg      <= '0;
      rsp_tag_reg    <= '0;
      rsp_result_reg <= '0;
      rsp_flags_reg  <= '0;
      rsp_mode_reg   <= '0;
      rsp_err_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;

      // Reserved opcodes never reach the FPU, so its operand bus keeps the last issue.
      if (pop) begin
        rsp_tag_reg <= head.tag;
        if (head.opcode == 2'b11) begin
          rsp_result_reg <= 32'h7FC0_0000;
          rsp_flags_reg  <= 4'h0;
          rsp_mode_reg   <= 2'b00;
          rsp_err_reg    <= 2'b01;
        end else begin
          fpu_op_reg <= head.opcode;
          fpu_a_reg  <= head.a;
          fpu_b_reg  <= head.b;
        end
      end

      if (state_reg == S_ISSUE)                          wd_reg <= '0;
      else if (state_reg == S_WAIT && !bus.fpu_valid_out) wd_reg <= wd_reg + WD_ONE;

      if (fpu_done) begin
        rsp_result_reg <= bus.fpu_result;
        rsp_flags_reg  <= bus.fpu_flags;
        rsp_mode_reg   <= mode_in;
        rsp_err_reg    <= 2'b00;
      end else if (wd_expire) begin
        rsp_result_reg <= 32'h0;
        rsp_flags_reg  <= 4'h0;
        rsp_mode_reg   <= 2'b00;
        rsp_err_reg    <= 2'b10;
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [15:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst)
        cnt_reg <= '0;
      else if (fpu_done && mode_in == 2'(gi) && cnt_reg != 16'hFFFF)
        cnt_reg <= cnt_reg + 16'd1;
    end
    assign cnt_sat[gi] = cnt_reg;
  end

  assign cnt_fp32   = cnt_sat[0];
  assign cnt_approx = cnt_sat[1];
  assign cnt_bf16   = cnt_sat[2];

  assign bus.req_ready    = !fifo_full;
  assign bus.fpu_valid_in = (state_reg == S_ISSUE);
  assign bus.fpu_opcode   = fpu_op_reg;
  assign bus.fpu_a        = fpu_a_reg;
  assign bus.fpu_b        = fpu_b_reg;
  assign bus.rsp_valid    = (state_reg == S_RESP);
  assign bus.rsp_tag      = rsp_tag_reg;
  assign bus.rsp_result   = rsp_result_reg;
  assign bus.rsp_flags    = rsp_flags_reg;
  assign bus.rsp_mode     = rsp_mode_reg;
  assign bus.rsp_err      = rsp_err_reg;
  assign busy             = (state_reg != S_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios followed by a random run, all responses
// checked against a request-order scoreboard built from a behavioural FPU/response model.
module tb_fpu_issue_ctrl;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cnt_fp32, cnt_approx, cnt_bf16;
  logic        busy;

  fpu_issue_ctrl_if #(.TAG_W(4)) bus();

  fpu_issue_ctrl #(.DEPTH(4), .TAG_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cnt_fp32   (cnt_fp32),
    .cnt_approx (cnt_approx),
    .cnt_bf16   (cnt_bf16),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [1:0]  mode;
    logic [1:0]  err;
  } rsp_t;

  rsp_t        exp_q[$];
  int          cnt_model[3];
  int          n_vec = 0;
  int          n_err = 0;
  int          issue_cnt = 0;
  int          stray_cnt = 0;
  bit          fpu_enable = 1'b1;
  bit          force_en = 1'b0;
  logic [31:0] force_val = 32'h0;

  // Stand-in FPU arithmetic: integer ops on the raw words are enough to tell requests apart.
  function automatic logic [31:0] fake_fpu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (force_en) return force_val;
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      default: return a * b;
    endcase
  endfunction

  function automatic logic [3:0] fake_flags(input logic [31:0] r);
    return {r[31], r[30], r[0], (r == 32'h0)};
  endfunction

  function automatic rsp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] tag);
    rsp_t e;
    e.tag = tag;
    if (op == 2'b11) begin
      e.result = 32'h7FC0_0000; e.flags = 4'h0; e.mode = 2'b00; e.err = 2'b01;
    end else if (!fpu_enable) begin
      e.result = 32'h0; e.flags = 4'h0; e.mode = 2'b00; e.err = 2'b10;
    end else begin
      e.result = fake_fpu(op, a, b);
      e.flags  = fake_flags(e.result);
      e.mode   = b[0] ? 2'b10 : (a[0] ? 2'b01 : 2'b00);
      e.err    = 2'b00;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Records the handshakes that the coming edge will perform, then advances one cycle.
  task automatic cycle();
    rsp_t e;
    if (bus.req_valid && bus.req_ready) begin
      e = model(bus.req_opcode, bus.req_a, bus.req_b, bus.req_tag);
      exp_q.push_back(e);
      if (e.err == 2'b00) cnt_model[e.mode]++;
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_extra", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        $display("rsp tag=%0d result=%h flags=%h mode=%0d err=%0d", bus.rsp_tag, bus.rsp_result,
                 bus.rsp_flags, bus.rsp_mode, bus.rsp_err);
        check("rsp", 64'({bus.rsp_tag, bus.rsp_result, bus.rsp_flags, bus.rsp_mode, bus.rsp_err}), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag);
    bit acc = 1'b0;
    bus.req_valid = 1'b1; bus.req_opcode = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    for (int i = 0; i < 200 && !acc; i++) begin
      if (i > 8) bus.rsp_ready = 1'b1;
      acc = bus.req_ready;
      cycle();
    end
    bus.req_valid = 1'b0;
    if (!acc) check("push_timeout", 64'(acc), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      cycle();
    end
    check("drain", 64'(exp_q.size() == 0 && !busy), 64'd1);
  endtask

  task automatic check_counters(input string name);
    check({name, "_fp32"},   64'(cnt_fp32),   64'(cnt_model[0]));
    check({name, "_approx"}, 64'(cnt_approx), 64'(cnt_model[1]));
    check({name, "_bf16"},   64'(cnt_bf16),   64'(cnt_model[2]));
  endtask

  // FPU model: answers each issue after a short random delay, or never when disabled.
  initial begin : fpu_model
    bit          pend = 1'b0;
    int          cd = 0;
    int          stray_done = 0;
    logic [1:0]  p_op = '0;
    logic [31:0] p_a = '0, p_b = '0;
    bus.fpu_valid_out = 1'b0; bus.fpu_result = '0; bus.fpu_flags = '0;
    bus.fpu_used_approx = 1'b0; bus.fpu_used_bf16 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.fpu_valid_out = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (cd == 0) begin
            bus.fpu_valid_out   = 1'b1;
            bus.fpu_result      = fake_fpu(p_op, p_a, p_b);
            bus.fpu_flags       = fake_flags(bus.fpu_result);
            bus.fpu_used_approx = p_a[0];
            bus.fpu_used_bf16   = p_b[0];
            pend = 1'b0;
          end else begin
            cd--;
          end
        end else if (stray_done < stray_cnt) begin
          bus.fpu_valid_out = 1'b1;
          bus.fpu_result    = 32'hDEAD_BEEF;
          bus.fpu_used_bf16 = 1'b1;
          stray_done++;
        end
        if (bus.fpu_valid_in) begin
          issue_cnt++;
          if (fpu_enable) begin
            pend = 1'b1; cd = $urandom_range(0, 2);
            p_op = bus.fpu_opcode; p_a = bus.fpu_a; p_b = bus.fpu_b;
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    int snap;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_fpu_valid_in", 64'(bus.fpu_valid_in), 64'd0);
    check("rst_fpu_a", 64'(bus.fpu_a), 64'd0);
    check_counters("rst_cnt");

    // Single add with a known IEEE result
    force_en = 1'b1; force_val = 32'h4040_0000;
    push_req(2'b00, 32'h3F80_0000, 32'h4000_0000, 4'd3);
    wait_idle();
    force_en = 1'b0;
    check_counters("t1_cnt");

    // Fill the FIFO while the first response is held, then drain in order
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_req(2'(i % 3), 32'h1000 * (i + 1), 32'h22 + 2 * i, 4'(i + 1));
    check("t2_full_req_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 1'b1; bus.req_tag = 4'd9;
    cycle(); cycle();
    bus.req_valid = 1'b0;
    check("t2_blocked_req_ready", 64'(bus.req_ready), 64'd0);
    bus.rsp_ready = 1'b1;
    wait_idle();
    check_counters("t2_cnt");

    // Reserved opcode bypasses the FPU
    snap = issue_cnt;
    push_req(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 4'd7);
    wait_idle();
    check("t3_no_issue", 64'(issue_cnt), 64'(snap));
    check_counters("t3_cnt");

    // Watchdog timeout, then a stray strobe, then normal operation
    fpu_enable = 1'b0;
    push_req(2'b10, 32'h40, 32'h60, 4'd5);
    for (int i = 0; i < 20 && !bus.fpu_valid_in; i++) cycle();
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      cycle();
      n++;
    end
    check("t4_timeout_cycles", 64'(n), 64'(TIMEOUT + 1));
    wait_idle();
    stray_cnt++;
    repeat (3) cycle();
    check("t4_stray_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("t4_stray_busy", 64'(busy), 64'd0);
    check_counters("t4_stray_cnt");
    fpu_enable = 1'b1;
    push_req(2'b01, 32'h0000_0500, 32'h0000_0100, 4'd6);
    wait_idle();
    check_counters("t4_cnt");

    // Backpressure: held response stays stable and nothing new issues
    bus.rsp_ready = 1'b0;
    push_req(2'b10, 32'h0000_0032, 32'h0000_0005, 4'd10);
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) cycle();
    snap = issue_cnt;
    push_req(2'b00, 32'h0000_0100, 32'h0000_0200, 4'd11);
    for (int i = 0; i < 10; i++) begin
      check("t5_hold", 64'({bus.rsp_valid, bus.rsp_tag, bus.rsp_result, bus.rsp_mode, bus.rsp_err}),
            64'({1'b1, exp_q[0].tag, exp_q[0].result, exp_q[0].mode, exp_q[0].err}));
      cycle();
    end
    check("t5_no_issue", 64'(issue_cnt), 64'(snap));
    check("t5_mode", 64'(bus.rsp_mode), 64'd2);
    bus.rsp_ready = 1'b1;
    wait_idle();
    check_counters("t5_cnt");

    // Reset while waiting on the FPU with two requests queued
    fpu_enable = 1'b0;
    for (int i = 0; i < 3; i++) push_req(2'b00, 32'h10 + i, 32'h20, 4'(12 + i));
    cycle();
    rst = 1'b1;
    cycle();
    check("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_req_ready", 64'(bus.req_ready), 64'd1);
    exp_q.delete();
    cnt_model = '{0, 0, 0};
    check_counters("t6_cnt");
    rst = 1'b0;
    fpu_enable = 1'b1;
    cycle();

    // Random traffic with random backpressure
    for (int i = 0; i < 40; i++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 2)) cycle();
      push_req(2'($urandom_range(0, 3)), $urandom, $urandom, 4'(i));
    end
    bus.rsp_ready = 1'b1;
    wait_idle();
    check_counters("rand_cnt");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
